reg_dump_reader: RTL and testbench
==================================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, giving the number of registers dumped (NREGS >= 2).
REQ-003 SHALL have localparam ADDR_W = $clog2(NREGS).
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request a dump; sampled only in IDLE.
REQ-007 rd_addr  output  ADDR_W  register-file read address.
REQ-008 rd_data  input  WIDTH  register-file combinational read data for rd_addr.
REQ-009 out_valid  output  1  out_data/out_addr/out_last hold a beat.
REQ-010 out_ready  input  1  consumer accepts the beat when out_valid=1.
REQ-011 out_data  output  WIDTH  dumped register value (or checksum).
REQ-012 out_addr  output  ADDR_W  index of the register in out_data.
REQ-013 out_last  output  1  final beat of the dump.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, READ, SEND, CSUM, DONE.
REQ-017 IDLE: start=1 -> READ, with address counter cleared to 0; start=0 -> stay in IDLE.
REQ-018 READ (1 cycle): register rd_data into out_data and rd_addr into out_addr -> SEND.
REQ-019 SEND: out_valid=1; out_data, out_addr and out_last SHALL be stable until out_valid&&out_ready.
REQ-020 SEND handshake on counter < NREGS-1: increment counter -> READ.
REQ-021 SEND handshake on counter = NREGS-1: -> CSUM if REG_DUMP_CSUM_EN is defined, else -> DONE.
REQ-022 DONE: done=1 for exactly one cycle -> IDLE.
REQ-023 rd_addr SHALL equal the address counter at all times; the counter SHALL never exceed NREGS-1 and SHALL never wrap.
REQ-024 Latency: with out_ready held at 1, the first out_valid SHALL occur 2 cycles after start is sampled; each subsequent beat SHALL follow 2 cycles later.
REQ-025 start while busy=1 SHALL be ignored; no restart and no queuing.
REQ-026 out_valid SHALL be 0 in IDLE, READ and DONE.
REQ-027 out_last SHALL be 1 only on the final beat (the checksum beat when enabled, register NREGS-1 otherwise).

Reset
REQ-028 rst SHALL force state=IDLE, counter=0, out_data=0, out_addr=0, out_valid=0, out_last=0, busy=0, done=0 and the checksum accumulator to 0.
REQ-029 rst asserted mid-dump SHALL abort the dump; no further beats and no done pulse SHALL be produced.
REQ-030 rst SHALL take priority over start and over an out_valid&&out_ready handshake in the same cycle.

Configuration
REQ-031 Macro REG_DUMP_CSUM_EN SHALL control the checksum beat.
REQ-032 With REG_DUMP_CSUM_EN defined: the accumulator SHALL be cleared on leaving IDLE and XOR in each value captured in READ.
REQ-033 With REG_DUMP_CSUM_EN defined: CSUM SHALL present one beat with out_data = accumulator, out_addr = 0 and out_last = 1, holding until the handshake, then go to DONE.
REQ-034 Without REG_DUMP_CSUM_EN: the CSUM state and the accumulator SHALL be absent, and the dump SHALL be exactly NREGS beats.

Structure
REQ-035 Shared package reg_dump_pkg SHALL hold the state enum type (reg_dump_state_t) and the default WIDTH and NREGS constants.
REQ-036 The checksum accumulator SHALL be the sub-module dump_csum_acc (clear, enable, data in; WIDTH-wide XOR register), instantiated only under REG_DUMP_CSUM_EN.

Verification
REQ-037 Regfile reg[i]=32'h1000_0000+i, out_ready=1, pulse start -> 32 beats, out_addr 0..31 with matching data, first out_valid 2 cycles after start, done 1 cycle after the last beat.
REQ-038 Same regfile, out_ready low for 5 cycles on beat 7 -> beat 7 held stable for all 5 cycles, then the dump continues; no beat lost or duplicated.
REQ-039 start pulsed again at beat 10 -> ignored; exactly 32 beats and one done pulse.
REQ-040 rst asserted for 1 cycle during beat 15 SEND -> the next cycle shows IDLE, all outputs 0, no done; a new start then dumps from address 0.
REQ-041 REG_DUMP_CSUM_EN, all registers 32'hFFFF_FFFF -> 33 beats; the checksum beat has out_data=32'h0000_0000 and out_last=1.
REQ-042 NREGS=2, WIDTH=8, regs 8'hA5, 8'h3C, no CSUM -> 2 beats, out_last on the beat with out_addr=1, counter does not wrap.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register dump reader.
// The CSUM state exists only when REG_DUMP_CSUM_EN is defined.
package reg_dump_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultNregs = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StSend,
`ifdef REG_DUMP_CSUM_EN
        StCsum,
`endif
        StDone
    } reg_dump_state_t;

endpackage

// File: rtl/reg_dump_reader_csum_acc.sv
// dump_csum_acc: WIDTH-wide XOR accumulator for the optional checksum beat.
// Clear wins over enable so a fresh dump never inherits a stale sum.
module dump_csum_acc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= acc_q ^ din;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks a register file and streams each value out over a valid/ready port.
// Define REG_DUMP_CSUM_EN to append an XOR checksum beat after the last register.
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned NREGS  = DefaultNregs,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NREGS - 1);

    reg_dump_state_t   state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;

`ifdef REG_DUMP_CSUM_EN
    logic             csum_clear;
    logic             csum_enable;
    logic [WIDTH-1:0] csum_value;

    dump_csum_acc #(
        .WIDTH (WIDTH)
    ) u_csum_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (csum_clear),
        .enable (csum_enable),
        .din    (rd_data),
        .acc    (csum_value)
    );
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        addr_d    = addr_q;
        last_d    = last_q;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
`ifdef REG_DUMP_CSUM_EN
        csum_clear  = 1'b0;
        csum_enable = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d = StRead;
                    cnt_d   = '0;
`ifdef REG_DUMP_CSUM_EN
                    csum_clear = 1'b1;
`endif
                end
            end
            StRead: begin
                data_d  = rd_data;
                addr_d  = cnt_q;
`ifdef REG_DUMP_CSUM_EN
                last_d      = 1'b0;
                csum_enable = 1'b1;
`else
                last_d = (cnt_q == LastAddr);
`endif
                state_d = StSend;
            end
            StSend: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_q == LastAddr) begin
`ifdef REG_DUMP_CSUM_EN
                        // Accumulator already holds every captured value here.
                        state_d = StCsum;
                        data_d  = csum_value;
                        addr_d  = '0;
                        last_d  = 1'b1;
`else
                        state_d = StDone;
`endif
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = StRead;
                    end
                end
            end
`ifdef REG_DUMP_CSUM_EN
            StCsum: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    assign rd_addr  = cnt_q;
    assign out_data = data_q;
    assign out_addr = addr_q;
    assign out_last = last_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: default 32x32 instance plus an NREGS=2, WIDTH=8 instance.
// Checksum expectations switch on when REG_DUMP_CSUM_EN is defined.
module tb_reg_dump_reader;

    localparam int N = 32;
`ifdef REG_DUMP_CSUM_EN
    localparam int Csum = 1;
`else
    localparam int Csum = 0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, out_ready, all_ones;
    logic [4:0]  rd_addr, out_addr;
    logic [31:0] rd_data, out_data;
    logic        out_valid, out_last, busy, done;

    assign rd_data = all_ones ? 32'hFFFF_FFFF : 32'h1000_0000 + {27'd0, rd_addr};

    reg_dump_reader u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    logic       s_rst, s_start, s_ready;
    logic [0:0] s_rd_addr, s_out_addr;
    logic [7:0] s_rd_data, s_out_data;
    logic       s_valid, s_last, s_busy, s_done;

    assign s_rd_data = s_rd_addr[0] ? 8'h3C : 8'hA5;

    reg_dump_reader #(
        .WIDTH (8),
        .NREGS (2)
    ) u_small (
        .clk       (clk),
        .rst       (s_rst),
        .start     (s_start),
        .rd_addr   (s_rd_addr),
        .rd_data   (s_rd_data),
        .out_valid (s_valid),
        .out_ready (s_ready),
        .out_data  (s_out_data),
        .out_addr  (s_out_addr),
        .out_last  (s_last),
        .busy      (s_busy),
        .done      (s_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_val(input int i);
        return all_ones ? 32'hFFFF_FFFF : 32'h1000_0000 + i;
    endfunction

    function automatic logic [31:0] exp_data(input int b);
        logic [31:0] x;
        if (b < N) return reg_val(b);
        x = '0;
        for (int i = 0; i < N; i++) x = x ^ reg_val(i);
        return x;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_addr"}, out_addr, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
    endtask

    // Runs one dump; negative beat indices disable the stall / restart / reset events.
    task automatic run_dump(input int stall_beat, input int restart_beat, input int rst_beat);
        int          beat = 0;
        int          cyc = 0;
        int          stall = 0;
        int          last_hs = -10;
        int          ndone = 0;
        int          extra = 0;
        logic [31:0] hd;
        logic [4:0]  ha;
        logic        hl;
        start = 1'b1;
        step();
        start = 1'b0;
        check("read_no_valid", out_valid, 0);
        check("read_busy", busy, 1);
        step();
        check("first_valid_2cyc", out_valid, 1);
        while (cyc < 400 && ndone == 0) begin
            out_ready = 1'b1;
            start = 1'b0;
            if (out_valid) begin
                if (beat == rst_beat) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    check_idle("abort");
                    for (int i = 0; i < 5; i++) begin
                        step();
                        if (out_valid || done) extra++;
                    end
                    check("abort_quiet", extra, 0);
                    return;
                end
                check("rd_addr_track", rd_addr, (beat < N) ? beat : N - 1);
                if (beat == stall_beat && stall < 5) begin
                    if (stall == 0) begin
                        hd = out_data;
                        ha = out_addr;
                        hl = out_last;
                    end else begin
                        check("stall_hold", {out_data, out_addr, out_last}, {hd, ha, hl});
                    end
                    out_ready = 1'b0;
                    stall++;
                end
                if (beat == restart_beat) start = 1'b1;
                if (out_ready) begin
                    check("beat_addr", out_addr, (beat < N) ? beat : 0);
                    check("beat_data", out_data, exp_data(beat));
                    check("beat_last", out_last, beat == N - 1 + Csum);
                    last_hs = cyc;
                    beat++;
                end
            end
            if (done) begin
                ndone++;
                check("done_after_last", cyc - last_hs, 1);
            end
            step();
            cyc++;
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid || done) extra++;
            step();
        end
        check("beat_count", beat, N + Csum);
        check("done_count", ndone, 1);
        check("no_extra", extra, 0);
        check("busy_after", busy, 0);
        check("no_wrap", rd_addr, N - 1);
        if (stall_beat >= 0) check("stall_cycles", stall, 5);
    endtask

    initial begin
        int sb = 0;
        logic [7:0] s_exp;
        rst = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        all_ones = 1'b0;
        s_rst = 1'b1;
        s_start = 1'b0;
        s_ready = 1'b1;
        step();
        step();
        check_idle("reset");
        start = 1'b0;
        rst = 1'b0;
        s_rst = 1'b0;
        step();
        check_idle("post_reset");

        run_dump(-1, -1, -1);
        run_dump(7, -1, -1);
        run_dump(-1, 10, -1);
        run_dump(-1, -1, 15);
        run_dump(-1, -1, -1);
        all_ones = 1'b1;
        run_dump(-1, -1, -1);

        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int c = 0; c < 20 && !s_done; c++) begin
            if (s_valid) begin
                s_exp = (sb == 0) ? 8'hA5 : (sb == 1) ? 8'h3C : 8'h99;
                check("small_addr", s_out_addr, (sb == 1) ? 1 : 0);
                check("small_data", s_out_data, s_exp);
                check("small_last", s_last, sb == 1 + Csum);
                sb++;
            end
            step();
        end
        check("small_done", s_done, 1);
        check("small_beats", sb, 2 + Csum);
        check("small_no_wrap", s_rd_addr, 1);
        step();
        check("small_idle", s_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
